// File: rtl/char_mover.sv
// ---------------------------------------------------------------------------
// char_mover -- tile-maze character movement controller.
//
// Once per video frame (i_frame_tick) the character either steps one pixel,
// or, when sitting exactly on a tile, first asks the map whether the tile
// next to it is blocked: the requested turn direction first (CHECK_TURN),
// then straight ahead (CHECK_AHEAD). A request for the opposite direction
// reverses at once, with no map query.
//
// Ports
//   i_clk, i_rst              clock, asynchronous active-high reset
//   i_frame_tick              one-cycle pulse per frame; ignored while busy
//   i_dir_valid, i_dir        direction request (0=-x 1=+x 2=-y 3=+y)
//   o_wall_req                map query valid, held until acknowledged
//   o_wall_tile_x/_y          tile being queried
//   i_wall_ack, i_wall_is_wall  map answer (is_wall valid with ack)
//   o_char_x, o_char_y        sprite top-left pixel position
//   o_dir, o_moving, o_busy   heading, advancing flag, FSM not idle
//
// Build option
//   CHAR_MOVER_PRETURN_EN     keep a pending turn request across ticks until
//                             it is taken or overwritten. Without it a request
//                             only counts on the first tick after it is made.
// ---------------------------------------------------------------------------
module char_mover #(
    parameter int unsigned START_X   = 128,
    parameter int unsigned START_Y   = 104,
    parameter logic [1:0]  START_DIR = 2'd1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_frame_tick,
    input  logic       i_dir_valid,
    input  logic [1:0] i_dir,
    output logic       o_wall_req,
    output logic [5:0] o_wall_tile_x,
    output logic [4:0] o_wall_tile_y,
    input  logic       i_wall_ack,
    input  logic       i_wall_is_wall,
    output logic [9:0] o_char_x,
    output logic [9:0] o_char_y,
    output logic [1:0] o_dir,
    output logic       o_moving,
    output logic       o_busy
);
    localparam logic [9:0] X_MAX  = 10'd287;
    localparam logic [9:0] Y_MAX  = 10'd223;
    localparam logic [5:0] TX_MAX = 6'd35;
    localparam logic [4:0] TY_MAX = 5'd27;

    localparam logic [1:0] DIR_NX = 2'd0;
    localparam logic [1:0] DIR_PX = 2'd1;
    localparam logic [1:0] DIR_NY = 2'd2;
    localparam logic [1:0] DIR_PY = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK_TURN,
        S_CHECK_AHEAD,
        S_MOVE
    } state_t;

    state_t     state, state_nx;
    logic [1:0] pend_dir, turn_dir, dir_nx, q_dir;
    logic       pend_vld, pend_clr, seq_end, moving_nx;
    logic       aligned, ack, opposite, entering_query;
    logic [5:0] cur_tx, q_tx;
    logic [4:0] cur_ty, q_ty;

    assign aligned  = (o_char_x[2:0] == 3'd0) && (o_char_y[2:0] == 3'd0);
    assign cur_tx   = o_char_x[8:3];
    assign cur_ty   = o_char_y[7:3];
    // An ack only means something while a query is outstanding.
    assign ack      = i_wall_ack && o_wall_req;
    assign opposite = (pend_dir == {o_dir[1], ~o_dir[0]});
    assign o_busy   = (state != S_IDLE);

    // Next state / next heading.
    always_comb begin
        state_nx  = state;
        dir_nx    = o_dir;
        moving_nx = o_moving;
        pend_clr  = 1'b0;
        seq_end   = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_frame_tick) begin
                    if (pend_vld && opposite) begin
                        dir_nx    = pend_dir;
                        pend_clr  = 1'b1;
                        moving_nx = 1'b1;
                        state_nx  = S_MOVE;
                    end else if (aligned && pend_vld && (pend_dir != o_dir || !o_moving)) begin
                        // A request along the current heading still has to
                        // be checked when standing still: it starts movement.
                        state_nx = S_CHECK_TURN;
                    end else if (aligned && o_moving) begin
                        state_nx = S_CHECK_AHEAD;
                    end else if (o_moving) begin
                        state_nx = S_MOVE;
                    end else begin
                        seq_end = 1'b1;
                    end
                end
            end
            S_CHECK_TURN: begin
                if (ack) begin
                    if (!i_wall_is_wall) begin
                        dir_nx    = turn_dir;
                        pend_clr  = 1'b1;
                        moving_nx = 1'b1;
                        state_nx  = S_MOVE;
                    end else begin
                        state_nx = S_CHECK_AHEAD;
                    end
                end
            end
            S_CHECK_AHEAD: begin
                if (ack) begin
                    if (!i_wall_is_wall) begin
                        state_nx = S_MOVE;
                    end else begin
                        moving_nx = 1'b0;
                        state_nx  = S_IDLE;
                        seq_end   = 1'b1;
                    end
                end
            end
            S_MOVE: begin
                state_nx = S_IDLE;
                seq_end  = 1'b1;
            end
            default: state_nx = S_IDLE;
        endcase
`ifndef CHAR_MOVER_PRETURN_EN
        if (seq_end) pend_clr = 1'b1;
`endif
    end

    // Neighbour of the current tile in the direction about to be queried.
    assign q_dir = (state_nx == S_CHECK_TURN) ? pend_dir : o_dir;

    always_comb begin
        q_tx = cur_tx;
        q_ty = cur_ty;
        case (q_dir)
            DIR_NX: q_tx = (cur_tx == 6'd0)   ? TX_MAX : cur_tx - 6'd1;
            DIR_PX: q_tx = (cur_tx == TX_MAX) ? 6'd0   : cur_tx + 6'd1;
            DIR_NY: q_ty = (cur_ty == 5'd0)   ? TY_MAX : cur_ty - 5'd1;
            DIR_PY: q_ty = (cur_ty == TY_MAX) ? 5'd0   : cur_ty + 5'd1;
            default: ;
        endcase
    end

    // A blocked turn goes straight into the ahead query, so req stays high
    // across that boundary with the new tile loaded on the same edge.
    assign entering_query = (state_nx != state) &&
                            (state_nx == S_CHECK_TURN || state_nx == S_CHECK_AHEAD);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= S_IDLE;
            o_char_x      <= 10'(START_X);
            o_char_y      <= 10'(START_Y);
            o_dir         <= START_DIR;
            o_moving      <= 1'b0;
            pend_dir      <= 2'd0;
            pend_vld      <= 1'b0;
            turn_dir      <= 2'd0;
            o_wall_req    <= 1'b0;
            o_wall_tile_x <= 6'd0;
            o_wall_tile_y <= 5'd0;
        end else begin
            state    <= state_nx;
            o_dir    <= dir_nx;
            o_moving <= moving_nx;

            // A fresh strobe beats a clear in the same cycle.
            if (i_dir_valid) begin
                pend_dir <= i_dir;
                pend_vld <= 1'b1;
            end else if (pend_clr) begin
                pend_vld <= 1'b0;
            end

            // Freeze the direction that was actually checked; a strobe during
            // the wait must not be adopted unchecked.
            if (state_nx == S_CHECK_TURN && state != S_CHECK_TURN)
                turn_dir <= pend_dir;

            o_wall_req <= (state_nx == S_CHECK_TURN) || (state_nx == S_CHECK_AHEAD);
            if (entering_query) begin
                o_wall_tile_x <= q_tx;
                o_wall_tile_y <= q_ty;
            end

            if (state == S_MOVE) begin
                case (o_dir)
                    DIR_NX: o_char_x <= (o_char_x == 10'd0) ? X_MAX : o_char_x - 10'd1;
                    DIR_PX: o_char_x <= (o_char_x == X_MAX) ? 10'd0 : o_char_x + 10'd1;
                    DIR_NY: o_char_y <= (o_char_y == 10'd0) ? Y_MAX : o_char_y - 10'd1;
                    DIR_PY: o_char_y <= (o_char_y == Y_MAX) ? 10'd0 : o_char_y + 10'd1;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_char_mover.sv
module tb_char_mover;
    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic       i_frame_tick = 1'b0;
    logic       i_dir_valid = 1'b0;
    logic [1:0] i_dir = 2'd0;
    logic       o_wall_req;
    logic [5:0] o_wall_tile_x;
    logic [4:0] o_wall_tile_y;
    logic       i_wall_ack = 1'b0;
    logic       i_wall_is_wall = 1'b0;
    logic [9:0] o_char_x;
    logic [9:0] o_char_y;
    logic [1:0] o_dir;
    logic       o_moving;
    logic       o_busy;

    char_mover dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_frame_tick(i_frame_tick),
        .i_dir_valid(i_dir_valid), .i_dir(i_dir),
        .o_wall_req(o_wall_req), .o_wall_tile_x(o_wall_tile_x), .o_wall_tile_y(o_wall_tile_y),
        .i_wall_ack(i_wall_ack), .i_wall_is_wall(i_wall_is_wall),
        .o_char_x(o_char_x), .o_char_y(o_char_y), .o_dir(o_dir),
        .o_moving(o_moving), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    bit wall_map [36][28];
    bit auto_resp = 1'b1;
    bit in_q = 1'b0;
    int lat = 0;
    int q_tx[$], q_ty[$];     // tiles the DUT actually queried
    int eq_tx[$], eq_ty[$];   // tiles the model expects to be queried

    // reference model state
    int m_x, m_y, m_dir;
    bit m_mov, m_pv;
    int m_pd;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock; the map responder runs here so it shares this process.
    task automatic cyc();
        int tx, ty;
        @(negedge i_clk);
        if (auto_resp) begin
            if (i_wall_ack) begin
                i_wall_ack = 1'b0;
            end else if (o_wall_req) begin
                tx = int'(o_wall_tile_x);
                ty = int'(o_wall_tile_y);
                if (!in_q) begin
                    in_q = 1'b1;
                    lat  = int'($urandom_range(0, 3));
                    q_tx.push_back(tx);
                    q_ty.push_back(ty);
                end
                if (lat == 0) begin
                    i_wall_ack     = 1'b1;
                    i_wall_is_wall = (tx < 36 && ty < 28) ? wall_map[tx][ty] : 1'b1;
                    in_q           = 1'b0;
                end else begin
                    lat--;
                end
            end
        end
    endtask

    task automatic clear_map();
        for (int a = 0; a < 36; a++)
            for (int b = 0; b < 28; b++)
                wall_map[a][b] = 1'b0;
    endtask

    task automatic do_reset();
        cyc();
        i_rst = 1'b1; i_wall_ack = 1'b0; i_frame_tick = 1'b0; i_dir_valid = 1'b0;
        in_q = 1'b0;
        q_tx.delete(); q_ty.delete(); eq_tx.delete(); eq_ty.delete();
        cyc();
        i_rst = 1'b0;
        cyc();
        m_x = 128; m_y = 104; m_dir = 1; m_mov = 0; m_pv = 0; m_pd = 0;
    endtask

    task automatic strobe(input int d);
        i_dir_valid = 1'b1; i_dir = 2'(d);
        cyc();
        i_dir_valid = 1'b0;
        m_pv = 1'b1; m_pd = d;
    endtask

    // Tick, then wait for idle, firing stray ticks while busy.
    task automatic tick_wait();
        int n = 0;
        i_frame_tick = 1'b1;
        cyc();
        i_frame_tick = 1'b0;
        while (o_busy && n < 300) begin
            i_frame_tick = ($urandom_range(0, 2) == 0);
            cyc();
            n++;
        end
        i_frame_tick = 1'b0;
        if (n >= 300) chk("idle_timeout", n, 0);
    endtask

    function automatic int opp(input int d);
        case (d)
            0: return 1;
            1: return 0;
            2: return 3;
            default: return 2;
        endcase
    endfunction

    task automatic mquery(input int tx, input int ty, input int d, output bit wall);
        int nx = tx, ny = ty;
        case (d)
            0: nx = (tx + 35) % 36;
            1: nx = (tx + 1) % 36;
            2: ny = (ty + 27) % 28;
            default: ny = (ty + 1) % 28;
        endcase
        eq_tx.push_back(nx); eq_ty.push_back(ny);
        wall = wall_map[nx][ny];
    endtask

    task automatic model_tick();
        bit step = 0, ahead = 0, w;
        bit al = (m_x % 8 == 0) && (m_y % 8 == 0);
        if (m_pv && m_pd == opp(m_dir)) begin
            m_dir = m_pd; m_pv = 0; m_mov = 1; step = 1;
        end else if (al && m_pv && (m_pd != m_dir || !m_mov)) begin
            mquery(m_x / 8, m_y / 8, m_pd, w);
            if (!w) begin m_dir = m_pd; m_pv = 0; m_mov = 1; step = 1; end
            else ahead = 1;
        end else if (al && m_mov) ahead = 1;
        else if (m_mov) step = 1;
        if (ahead) begin
            mquery(m_x / 8, m_y / 8, m_dir, w);
            if (!w) step = 1; else m_mov = 0;
        end
        if (step) begin
            case (m_dir)
                0: m_x = (m_x + 287) % 288;
                1: m_x = (m_x + 1) % 288;
                2: m_y = (m_y + 223) % 224;
                default: m_y = (m_y + 1) % 224;
            endcase
        end
`ifndef CHAR_MOVER_PRETURN_EN
        m_pv = 0;
`endif
    endtask

    task automatic cmp_queries(input string tag);
        chk({tag, "_nq"}, q_tx.size(), eq_tx.size());
        for (int k = 0; k < q_tx.size() && k < eq_tx.size(); k++) begin
            chk({tag, "_qtx"}, q_tx[k], eq_tx[k]);
            chk({tag, "_qty"}, q_ty[k], eq_ty[k]);
        end
        q_tx.delete(); q_ty.delete(); eq_tx.delete(); eq_ty.delete();
    endtask

    typedef struct {
        bit       do_strobe;
        int       sdir;
        bit [3:0] mask;   // wall at neighbour of tile (16,13) in direction k
        int       ex, ey, edir;
        bit       emov;
        int       nq, etx, ety;
    } vec_t;

    vec_t tbl[7];

    initial begin
        bit   stable;
        int   hx, hy;
        int   ntx[4] = '{15, 17, 16, 16};
        int   nty[4] = '{13, 13, 12, 14};

        // single tick from reset (128,104) heading +x, stopped
        tbl[0] = '{0, 0, 4'b0000, 128, 104, 1, 0, 0, 0, 0};
        tbl[1] = '{1, 1, 4'b0000, 129, 104, 1, 1, 1, 17, 13};
        tbl[2] = '{1, 1, 4'b0010, 128, 104, 1, 0, 2, 17, 13};
        tbl[3] = '{1, 0, 4'b0001, 127, 104, 0, 1, 0, 0, 0};
        tbl[4] = '{1, 2, 4'b0000, 128, 103, 2, 1, 1, 16, 12};
        tbl[5] = '{1, 3, 4'b1010, 128, 104, 1, 0, 2, 16, 14};
        tbl[6] = '{1, 3, 4'b0000, 128, 105, 3, 1, 1, 16, 14};

        // reset state, sampled while reset is held
        cyc();
        i_rst = 1'b1;
        #1;
        chk("rst_x", o_char_x, 128);
        chk("rst_y", o_char_y, 104);
        chk("rst_dir", o_dir, 1);
        chk("rst_moving", o_moving, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_req", o_wall_req, 0);
        chk("rst_tile", {o_wall_tile_x, o_wall_tile_y}, 0);

        for (int i = 0; i < 7; i++) begin
            do_reset();
            clear_map();
            for (int k = 0; k < 4; k++)
                if (tbl[i].mask[k]) wall_map[ntx[k]][nty[k]] = 1'b1;
            if (tbl[i].do_strobe) strobe(tbl[i].sdir);
            tick_wait();
            chk("tbl_x", o_char_x, tbl[i].ex);
            chk("tbl_y", o_char_y, tbl[i].ey);
            chk("tbl_dir", o_dir, tbl[i].edir);
            chk("tbl_moving", o_moving, tbl[i].emov);
            chk("tbl_nq", q_tx.size(), tbl[i].nq);
            if (tbl[i].nq > 0 && q_tx.size() > 0) begin
                chk("tbl_qtx", q_tx[0], tbl[i].etx);
                chk("tbl_qty", q_ty[0], tbl[i].ety);
            end
        end

        // unaligned step with no query, then blocked ahead at 136
        do_reset(); clear_map();
        strobe(1);
        for (int k = 0; k < 7; k++) tick_wait();
        chk("s24_x135", o_char_x, 135);
        q_tx.delete(); q_ty.delete();
        tick_wait();
        chk("s24_x136", o_char_x, 136);
        chk("s24_noquery", q_tx.size(), 0);
        wall_map[18][13] = 1'b1;
        tick_wait();
        chk("s24_nq", q_tx.size(), 1);
        if (q_tx.size() > 0) chk("s24_tile", q_tx[0] * 100 + q_ty[0], 1813);
        chk("s24_moving", o_moving, 0);
        chk("s24_x", o_char_x, 136);

        // immediate reversal mid-tile
        do_reset(); clear_map();
        strobe(1); tick_wait(); tick_wait();
        q_tx.delete(); q_ty.delete();
        strobe(0); tick_wait();
        chk("s25_dir", o_dir, 0);
        chk("s25_x", o_char_x, 129);
        chk("s25_noquery", q_tx.size(), 0);

        // tunnel wrap at x=0
        do_reset(); clear_map();
        strobe(0);
        for (int k = 0; k < 128; k++) tick_wait();
        chk("s26_x0", o_char_x, 0);
        q_tx.delete(); q_ty.delete();
        tick_wait();
        chk("s26_x287", o_char_x, 287);
        if (q_tx.size() > 0) chk("s26_tile", q_tx[0] * 100 + q_ty[0], 3513);
        else chk("s26_nq", 0, 1);
        tick_wait();
        chk("s26_x286", o_char_x, 286);

        // blocked turn at 136, then retry (or not) at 144
        do_reset(); clear_map();
        wall_map[17][12] = 1'b1;
        strobe(1);
        for (int k = 0; k < 8; k++) tick_wait();
        chk("s27_x136", o_char_x, 136);
        strobe(2); tick_wait();
        chk("s27_x137", o_char_x, 137);
        chk("s27_dir1", o_dir, 1);
        for (int k = 0; k < 7; k++) tick_wait();
        chk("s27_x144", o_char_x, 144);
        tick_wait();
`ifdef CHAR_MOVER_PRETURN_EN
        chk("s27_turn_dir", o_dir, 2);
        chk("s27_turn_y", o_char_y, 103);
        chk("s27_turn_x", o_char_x, 144);
`else
        chk("s27_noturn_dir", o_dir, 1);
        chk("s27_noturn_x", o_char_x, 145);
        chk("s27_noturn_y", o_char_y, 104);
`endif

        // slow ack with stray ticks, req held stable
        do_reset(); clear_map();
        strobe(1);
        for (int k = 0; k < 8; k++) tick_wait();
        auto_resp = 1'b0;
        i_frame_tick = 1'b1; cyc(); i_frame_tick = 1'b0;
        chk("s28_req", o_wall_req, 1);
        hx = o_wall_tile_x; hy = o_wall_tile_y;
        chk("s28_tile", hx * 100 + hy, 1813);
        stable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            i_frame_tick = (k % 6 == 3);
            cyc();
            if (!o_wall_req || o_wall_tile_x != 6'(hx) || o_wall_tile_y != 5'(hy)) stable = 1'b0;
        end
        i_frame_tick = 1'b0;
        chk("s28_stable", stable, 1);
        i_wall_ack = 1'b1; i_wall_is_wall = 1'b0;
        cyc();
        i_wall_ack = 1'b0;
        chk("s28_req_drop", o_wall_req, 0);
        cyc(); cyc();
        chk("s28_x", o_char_x, 137);
        chk("s28_busy", o_busy, 0);

        // reset in the middle of a query, then a late ack
        do_reset(); clear_map();
        strobe(1);
        i_frame_tick = 1'b1; cyc(); i_frame_tick = 1'b0;
        chk("s28r_req_on", o_wall_req, 1);
        i_rst = 1'b1;
        #1;
        chk("s28r_req_off", o_wall_req, 0);
        cyc();
        i_rst = 1'b0;
        cyc();
        i_wall_ack = 1'b1; i_wall_is_wall = 1'b0;
        cyc();
        i_wall_ack = 1'b0;
        cyc(); cyc();
        chk("s28r_busy", o_busy, 0);
        chk("s28r_x", o_char_x, 128);
        chk("s28r_moving", o_moving, 0);
        auto_resp = 1'b1;

        // random walk on a random map against the model
        do_reset();
        for (int a = 0; a < 36; a++)
            for (int b = 0; b < 28; b++)
                wall_map[a][b] = ($urandom_range(0, 4) == 0);
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 2) == 0) strobe(int'($urandom_range(0, 3)));
            tick_wait();
            model_tick();
            chk("rnd_x", o_char_x, m_x);
            chk("rnd_y", o_char_y, m_y);
            chk("rnd_dir", o_dir, m_dir);
            chk("rnd_moving", o_moving, m_mov);
            cmp_queries("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
